// File: rtl/nexys_starship_pkg.sv
// Shared types and widths for the starship gun and monster controllers.
package nexys_starship_pkg;

  localparam int unsigned HEAT_W = 4;
  localparam int unsigned HITS_W = 8;
  localparam int unsigned REP_W  = 4;

  // One-hot state encoding shared with the monster FSMs.
  typedef enum logic [3:0] {
    ST_INIT   = 4'b0001,
    ST_READY  = 4'b0010,
    ST_COOL   = 4'b0100,
    ST_BROKEN = 4'b1000
  } gun_state_e;

endpackage

// File: rtl/nexys_starship_bottom_gun_if.sv
// Game-control bundle between the bottom gun and its neighbours.
import nexys_starship_pkg::*;

interface nexys_starship_bottom_gun_if;
  logic              play_flag;
  logic              game_over;
  logic              fire_pulse;
  logic              repair_pulse;
  logic              bottom_monster;
  logic              kill_bottom;
  logic              bottom_broken;
  logic [HEAT_W-1:0] heat;
  logic [HITS_W-1:0] hits;
  logic              q_Init;
  logic              q_Ready;
  logic              q_Cool;
  logic              q_Broken;

  modport master (
    output play_flag, game_over, fire_pulse, repair_pulse, bottom_monster,
    input  kill_bottom, bottom_broken, heat, hits, q_Init, q_Ready, q_Cool, q_Broken
  );

  modport slave (
    input  play_flag, game_over, fire_pulse, repair_pulse, bottom_monster,
    output kill_bottom, bottom_broken, heat, hits, q_Init, q_Ready, q_Cool, q_Broken
  );
endinterface

// File: rtl/nexys_starship_down_counter.sv
// Loadable down counter that holds at zero; load has priority over enable.
module nexys_starship_down_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  // Count register: load, else decrement toward zero when enabled.
  always_ff @(posedge clk_i) begin
    if (rst_i)                     count_q <= '0;
    else if (load_i)               count_q <= load_val_i;
    else if (en_i && count_q != '0) count_q <= count_q - 1'b1;
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/nexys_starship_bottom_gun.sv
// Bottom laser gun: fires at the bottom monster, heats per shot, cools down
// between shots, decays heat while idle and breaks at maximum heat until repaired.
import nexys_starship_pkg::*;

module nexys_starship_bottom_gun #(
  parameter int unsigned COOLDOWN_CYCLES = 25_000_000,
  parameter int unsigned COOL_CYCLES     = 50_000_000,
  parameter int unsigned HEAT_MAX        = 4,
  parameter int unsigned REPAIR_PRESSES  = 3
) (
  input  logic Clk,
  input  logic Reset,
  nexys_starship_bottom_gun_if.slave gun
);

  localparam int unsigned CD_W   = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam int unsigned IDLE_W = (COOL_CYCLES > 1) ? $clog2(COOL_CYCLES) : 1;

  gun_state_e        state_q, state_d;
  logic [HEAT_W-1:0] heat_q, heat_d;
  logic [HITS_W-1:0] hits_q, hits_d;
  logic [REP_W-1:0]  rep_q, rep_d;
  logic              kill_q, kill_d;

  logic cd_load, cd_en, cd_zero;
  logic idle_load, idle_en, idle_zero;

  // Timers reload on entry to their state; the idle timer also reloads after each decay.
  assign cd_load   = (state_d == ST_COOL) && (state_q != ST_COOL);
  assign cd_en     = (state_q == ST_COOL);
  assign idle_load = (state_d == ST_READY) && ((state_q != ST_READY) || idle_zero);
  assign idle_en   = (state_q == ST_READY) && !gun.fire_pulse;

  nexys_starship_down_counter #(.W(CD_W)) u_cooldown (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .load_i     (cd_load),
    .load_val_i (CD_W'(COOLDOWN_CYCLES - 1)),
    .en_i       (cd_en),
    .zero_o     (cd_zero)
  );

  nexys_starship_down_counter #(.W(IDLE_W)) u_idle (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .load_i     (idle_load),
    .load_val_i (IDLE_W'(COOL_CYCLES - 1)),
    .en_i       (idle_en),
    .zero_o     (idle_zero)
  );

  // State and datapath registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_INIT;
      heat_q  <= '0;
      hits_q  <= '0;
      rep_q   <= '0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      heat_q  <= heat_d;
      hits_q  <= hits_d;
      rep_q   <= rep_d;
      kill_q  <= kill_d;
    end
  end

  // Next state and datapath updates; game_over overrides every state.
  always_comb begin
    state_d = state_q;
    heat_d  = heat_q;
    hits_d  = hits_q;
    rep_d   = rep_q;
    kill_d  = 1'b0;
    if (gun.game_over) begin
      state_d = ST_INIT;
      heat_d  = '0;
      rep_d   = '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (gun.play_flag) begin
            state_d = ST_READY;
            hits_d  = '0;
          end
        end
        ST_READY: begin
          if (gun.fire_pulse) begin
            heat_d = heat_q + 1'b1;
            if (gun.bottom_monster) begin
              kill_d = 1'b1;
              hits_d = (hits_q == '1) ? hits_q : hits_q + 1'b1;
            end
            state_d = (heat_q + 1'b1 == HEAT_W'(HEAT_MAX)) ? ST_BROKEN : ST_COOL;
          end else if (idle_zero && heat_q != '0) begin
            heat_d = heat_q - 1'b1;
          end
        end
        ST_COOL: begin
          if (cd_zero) state_d = ST_READY;
        end
        ST_BROKEN: begin
          if (gun.repair_pulse) begin
            if (rep_q == REP_W'(REPAIR_PRESSES - 1)) begin
              rep_d   = '0;
              heat_d  = '0;
              state_d = ST_READY;
            end else begin
              rep_d = rep_q + 1'b1;
            end
          end
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  assign gun.kill_bottom   = kill_q;
  assign gun.bottom_broken = (state_q == ST_BROKEN);
  assign gun.heat          = heat_q;
  assign gun.hits          = hits_q;
  assign gun.q_Init        = (state_q == ST_INIT);
  assign gun.q_Ready       = (state_q == ST_READY);
  assign gun.q_Cool        = (state_q == ST_COOL);
  assign gun.q_Broken      = (state_q == ST_BROKEN);

endmodule

// File: tb/tb_nexys_starship_bottom_gun.sv
// Bench for the bottom gun: directed scenarios plus random stimulus, all
// checked every cycle against a cycle-level behavioural model.
module tb_nexys_starship_bottom_gun;

  localparam int unsigned CD   = 4;
  localparam int unsigned COOL = 8;
  localparam int unsigned HMAX = 3;
  localparam int unsigned REP  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nexys_starship_bottom_gun_if bus ();

  nexys_starship_bottom_gun #(
    .COOLDOWN_CYCLES (CD),
    .COOL_CYCLES     (COOL),
    .HEAT_MAX        (HMAX),
    .REPAIR_PRESSES  (REP)
  ) dut (
    .Clk   (clk),
    .Reset (rst),
    .gun   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Model: mode 0 init, 1 ready, 2 cooldown, 3 broken.
  int unsigned m_mode = 0;
  int unsigned m_heat = 0;
  int unsigned m_hits = 0;
  int unsigned m_kill = 0;
  int unsigned m_cool_spent = 0;
  int unsigned m_idle = 0;
  int unsigned m_rep = 0;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, g, p, f, rp, m);
    if (r) begin
      m_mode = 0; m_heat = 0; m_hits = 0; m_kill = 0; m_rep = 0; m_idle = 0; m_cool_spent = 0;
    end else if (g) begin
      m_mode = 0; m_heat = 0; m_kill = 0; m_rep = 0;
    end else begin
      m_kill = 0;
      case (m_mode)
        0: if (p) begin m_mode = 1; m_hits = 0; m_idle = 0; end
        1: begin
          if (f) begin
            m_heat++;
            if (m) begin
              m_kill = 1;
              if (m_hits < 255) m_hits++;
            end
            m_cool_spent = 0;
            m_mode = (m_heat == HMAX) ? 3 : 2;
          end else begin
            m_idle++;
            if (m_idle == COOL) begin
              m_idle = 0;
              if (m_heat > 0) m_heat--;
            end
          end
        end
        2: begin
          m_cool_spent++;
          if (m_cool_spent == CD) begin m_mode = 1; m_idle = 0; end
        end
        default: begin
          if (rp) begin
            m_rep++;
            if (m_rep == REP) begin m_rep = 0; m_heat = 0; m_mode = 1; m_idle = 0; end
          end
        end
      endcase
    end
  endtask

  task automatic compare_all();
    logic [3:0] oh_exp;
    logic [3:0] oh_obs;
    oh_exp = 4'b1000 >> m_mode;
    oh_obs = {bus.q_Init, bus.q_Ready, bus.q_Cool, bus.q_Broken};
    check_eq("kill_bottom", bus.kill_bottom, m_kill);
    check_eq("heat", bus.heat, m_heat);
    check_eq("hits", bus.hits, m_hits);
    check_eq("bottom_broken", bus.bottom_broken, (m_mode == 3) ? 1 : 0);
    check_eq("state_onehot", oh_obs, oh_exp);
  endtask

  task automatic cyc(input bit r, g, p, f, rp, m);
    rst                = r;
    bus.game_over      = g;
    bus.play_flag      = p;
    bus.fire_pulse     = f;
    bus.repair_pulse   = rp;
    bus.bottom_monster = m;
    @(posedge clk);
    model_step(r, g, p, f, rp, m);
    #1;
    compare_all();
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(0, 0, 1, 0, 0, 0);
  endtask

  initial begin
    int unsigned kills;
    int unsigned guard;
    bus.game_over = 0; bus.play_flag = 0; bus.fire_pulse = 0;
    bus.repair_pulse = 0; bus.bottom_monster = 0;

    // Reset, then start the game.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check_eq("reset_init", bus.q_Init, 1);
    check_eq("reset_hits", bus.hits, 0);
    cyc(0, 0, 1, 0, 0, 0);
    check_eq("play_ready", bus.q_Ready, 1);

    // Hit with monster present; fire during cooldown is ignored.
    cyc(0, 0, 1, 1, 0, 1);
    check_eq("hit_kill", bus.kill_bottom, 1);
    check_eq("hit_hits", bus.hits, 1);
    check_eq("hit_heat", bus.heat, 1);
    cyc(0, 0, 1, 1, 0, 1);
    check_eq("kill_one_cycle", bus.kill_bottom, 0);
    check_eq("cool_n2", bus.q_Cool, 1);
    cyc(0, 0, 1, 1, 0, 1);
    cyc(0, 0, 1, 0, 0, 1);
    check_eq("cool_n4", bus.q_Cool, 1);
    cyc(0, 0, 1, 0, 0, 1);
    check_eq("ready_n5", bus.q_Ready, 1);

    // Miss: heats, no kill, full cooldown.
    cyc(0, 0, 1, 1, 0, 0);
    check_eq("miss_kill", bus.kill_bottom, 0);
    check_eq("miss_heat", bus.heat, 2);
    idle(4);
    check_eq("miss_ready", bus.q_Ready, 1);

    // Third shot breaks the gun; fire ignored; repair with one coincident fire.
    cyc(0, 0, 1, 1, 0, 1);
    check_eq("break_heat", bus.heat, 3);
    check_eq("break_flag", bus.bottom_broken, 1);
    cyc(0, 0, 1, 1, 0, 1);
    cyc(0, 0, 1, 0, 1, 0);
    cyc(0, 0, 1, 1, 1, 1);
    check_eq("still_broken", bus.bottom_broken, 1);
    cyc(0, 0, 1, 0, 1, 0);
    check_eq("repaired_ready", bus.q_Ready, 1);
    check_eq("repaired_heat", bus.heat, 0);

    // Heat decay while idle.
    cyc(0, 0, 1, 1, 0, 0);
    idle(4);
    cyc(0, 0, 1, 1, 0, 0);
    idle(4);
    check_eq("decay_start", bus.heat, 2);
    idle(7);
    check_eq("decay_7", bus.heat, 2);
    idle(1);
    check_eq("decay_8", bus.heat, 1);
    idle(16);
    check_eq("decay_24", bus.heat, 0);
    idle(10);
    check_eq("decay_floor", bus.heat, 0);

    // game_over during cooldown.
    cyc(0, 0, 1, 1, 0, 1);
    cyc(0, 1, 1, 0, 0, 0);
    check_eq("go_init", bus.q_Init, 1);
    check_eq("go_heat", bus.heat, 0);
    cyc(0, 0, 1, 0, 0, 0);

    // Reset while broken.
    for (int unsigned i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 1, 0, 1);
      idle(4);
    end
    check_eq("pre_rst_broken", bus.bottom_broken, 1);
    cyc(1, 0, 1, 0, 0, 0);
    check_eq("rst_broken_init", bus.q_Init, 1);
    check_eq("rst_broken_flag", bus.bottom_broken, 0);
    check_eq("rst_broken_hits", bus.hits, 0);
    check_eq("rst_broken_heat", bus.heat, 0);

    // Hits saturation.
    cyc(0, 0, 1, 0, 0, 0);
    kills = 0;
    guard = 0;
    while (kills < 260 && guard < 10000) begin
      guard++;
      if (m_mode == 3)      cyc(0, 0, 1, 0, 1, 0);
      else if (m_mode == 1) begin cyc(0, 0, 1, 1, 0, 1); kills++; end
      else                  cyc(0, 0, 1, 0, 0, 0);
    end
    check_eq("sat_budget", (guard < 10000) ? 1 : 0, 1);
    check_eq("hits_sat", bus.hits, 255);

    // Random traffic.
    for (int unsigned i = 0; i < 3000; i++) begin
      cyc(($urandom_range(199) == 0), ($urandom_range(59) == 0), ($urandom_range(7) != 0),
          ($urandom_range(2) == 0), ($urandom_range(2) == 0), $urandom_range(1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
